// File: rtl/moa_pkg.sv
// moa_pkg: shared types and default sizing for the A-MOA final adder.
//   state_e   : control FSM states of moa_final_adder
//   DEF_*     : default column count, accumulator headroom and segment width
//   calc_nseg : number of SEG-bit segments across the accumulator
package moa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam int DEF_W        = 16;
    localparam int DEF_ACC_BITS = 4;
    localparam int DEF_SEG      = 4;

    function automatic int calc_nseg(input int w, input int acc_bits, input int seg);
        return (w + acc_bits) / seg;
    endfunction

endpackage

// File: rtl/moa_seg_add3.sv
// moa_seg_add3: combinational SEG-bit three-operand adder with 2-bit carry-in.
//   a, b, c : SEG-bit operand slices
//   cin     : carry from the previous segment (0..2)
//   sum     : low SEG bits of a+b+c+cin
//   cout    : carry into the next segment (0..2)
module moa_seg_add3 #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic [SEG-1:0] c,
    input  logic [1:0]     cin,
    output logic [SEG-1:0] sum,
    output logic [1:0]     cout
);
    localparam int TW = SEG + 2;

    // 3*(2^SEG-1)+2 < 2^(SEG+2), so two extra bits always hold the total.
    logic [TW-1:0] t;

    assign t    = TW'(a) + TW'(b) + TW'(c) + TW'(cin);
    assign sum  = t[SEG-1:0];
    assign cout = t[TW-1:SEG];

endmodule

// File: rtl/moa_final_adder.sv
// moa_final_adder: segment-serial carry-propagate stage of the approximate
// multi-operand adder. Resolves compressor sum/carry rows into a binary
// result, accumulating beats until in_last, one SEG-bit segment per cycle.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input beat handshake
//   sum_vec, carry_vec   : column sum bits (weight 2^i) / carry bits (2^(i+1))
//   in_last              : final beat of an operand group
//   out_valid/out_ready  : result handshake
//   out_data, out_ovf    : group sum mod 2^OUT_W, sticky overflow flag
//   busy                 : FSM not idle
module moa_final_adder
    import moa_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int ACC_BITS = DEF_ACC_BITS,
    parameter int SEG      = DEF_SEG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          sum_vec,
    input  logic [W-1:0]          carry_vec,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W+ACC_BITS-1:0] out_data,
    output logic                  out_ovf,
    output logic                  busy
);
    localparam int OUT_W = W + ACC_BITS;
    localparam int NSEG  = calc_nseg(W, ACC_BITS, SEG);
    localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

    if ((OUT_W % SEG) != 0) begin : g_bad_seg
        $error("moa_final_adder: W+ACC_BITS must be a multiple of SEG");
    end

    state_e                     state_q, state_d;
    logic [NSEG-1:0][SEG-1:0]   acc_q, acc_d;
    logic [NSEG-1:0][SEG-1:0]   s_q, s_d;
    logic [NSEG-1:0][SEG-1:0]   c_q, c_d;
    logic                       last_q, last_d;
    logic [IDX_W-1:0]           seg_idx_q, seg_idx_d;
    logic [1:0]                 seg_carry_q, seg_carry_d;
    logic                       ovf_q, ovf_d;
    logic [OUT_W-1:0]           out_data_q, out_data_d;
    logic                       out_ovf_q, out_ovf_d;

    logic [SEG-1:0]             seg_sum;
    logic [1:0]                 seg_cout;

    // Single shared segment adder; operands selected by the current segment.
    moa_seg_add3 #(.SEG(SEG)) u_seg_add (
        .a    (acc_q[seg_idx_q]),
        .b    (s_q[seg_idx_q]),
        .c    (c_q[seg_idx_q]),
        .cin  (seg_carry_q),
        .sum  (seg_sum),
        .cout (seg_cout)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        s_d         = s_q;
        c_d         = c_q;
        last_d      = last_q;
        seg_idx_d   = seg_idx_q;
        seg_carry_d = seg_carry_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d         = OUT_W'(sum_vec);
                    c_d         = OUT_W'({carry_vec, 1'b0});
                    last_d      = in_last;
                    seg_idx_d   = '0;
                    seg_carry_d = '0;
                    state_d     = ADD;
                end
            end
            ADD: begin
                acc_d[seg_idx_q] = seg_sum;
                seg_carry_d      = seg_cout;
                seg_idx_d        = seg_idx_q + IDX_W'(1);
                if (seg_idx_q == LAST_IDX) begin
                    // Carry out of the top segment is dropped; the result wraps.
                    seg_idx_d   = '0;
                    seg_carry_d = '0;
                    if (seg_cout != 2'd0) begin
                        ovf_d = 1'b1;
                    end
                    if (last_q) begin
                        out_data_d = acc_d;
                        out_ovf_d  = ovf_d;
                        state_d    = OUT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            s_q         <= '0;
            c_q         <= '0;
            last_q      <= 1'b0;
            seg_idx_q   <= '0;
            seg_carry_q <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            s_q         <= s_d;
            c_q         <= c_d;
            last_q      <= last_d;
            seg_idx_q   <= seg_idx_d;
            seg_carry_q <= seg_carry_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_moa_final_adder.sv
module tb_moa_final_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sum_vec;
    logic [15:0] carry_vec;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;
    logic        out_ovf;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    moa_final_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic garble();
        sum_vec   = 16'($urandom);
        carry_vec = 16'($urandom);
        in_last   = 1'($urandom);
    endtask

    // Present one beat, wait for acceptance, then count edges until the block
    // frees the input (non-last) or raises out_valid (last).
    task automatic send_beat(input logic [15:0] s, input logic [15:0] c,
                             input logic l, input bit hold, output int lat);
        int n;
        n         = 0;
        in_valid  = 1'b1;
        sum_vec   = s;
        carry_vec = c;
        in_last   = l;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
        tick();
        if (hold) garble();
        else in_valid = 1'b0;
        lat = 0;
        if (!l) begin
            while (!in_ready && lat < 50) begin
                tick();
                lat++;
                if (hold) garble();
            end
        end else begin
            while (!out_valid && lat < 50) begin
                tick();
                lat++;
                if (hold) garble();
            end
        end
    endtask

    task automatic finish_out(input int delay, input bit hold);
        repeat (delay) begin
            tick();
            if (hold) garble();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (!hold) in_valid = 1'b0;
    endtask

    typedef struct {
        logic [15:0] s;
        logic [15:0] c;
        logic        l;
        logic [19:0] exp_d;
        logic        exp_o;
    } vec_t;

    function automatic logic [15:0] pick();
        if ($urandom_range(0, 1) == 1) return 16'hFFFF - 16'($urandom_range(0, 255));
        return 16'($urandom);
    endfunction

    initial begin
        vec_t   vecs[13];
        int     lat;
        int     bad;
        longint total;
        int     nb;
        bit     hold;
        logic [15:0] s, c;
        logic   l;

        // Test 1, test 2, test 3 (9 beats + follow-up group)
        vecs[0]  = '{16'h00FF, 16'h0001, 1'b1, 20'h00101, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'hFFFF, 1'b0, 20'h0,     1'b0};
        vecs[2]  = '{16'h0001, 16'h0000, 1'b1, 20'h2FFFE, 1'b0};
        for (int i = 3; i <= 10; i++) vecs[i] = '{16'hFFFF, 16'hFFFF, 1'b0, 20'h0, 1'b0};
        vecs[11] = '{16'hFFFF, 16'hFFFF, 1'b1, 20'hAFFE5, 1'b1};
        vecs[12] = '{16'h0001, 16'h0000, 1'b1, 20'h00001, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        sum_vec   = '0;
        carry_vec = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_ovf",   32'(out_ovf),   32'd0);

        for (int i = 0; i < 13; i++) begin
            send_beat(vecs[i].s, vecs[i].c, vecs[i].l, 1'b0, lat);
            if (!vecs[i].l) begin
                chk("lat_in_ready", 32'(lat), 32'd5);
            end else begin
                chk("lat_out_valid", 32'(lat), 32'd5);
                chk("vec_data", 32'(out_data), 32'(vecs[i].exp_d));
                chk("vec_ovf",  32'(out_ovf),  32'(vecs[i].exp_o));
                finish_out(0, 1'b0);
                chk("vec_ready_after_hs", 32'(in_ready), 32'd1);
            end
        end

        // Backpressure with in_valid held through OUT and the handshake edge
        send_beat(16'h00FF, 16'h0001, 1'b1, 1'b0, lat);
        chk("bp_lat", 32'(lat), 32'd5);
        in_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            garble();
            tick();
            if (out_valid !== 1'b1 || out_data !== 20'h00101 || in_ready !== 1'b0) bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        chk("bp_data", 32'(out_data), 32'h00101);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_no_bypass_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("bp_still_idle", 32'(busy), 32'd0);

        // Reset while segment 2 is being added
        in_valid  = 1'b1;
        sum_vec   = 16'hFFFF;
        carry_vec = 16'hFFFF;
        in_last   = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data",  32'(out_data),  32'd0);
        chk("mid_rst_out_ovf",   32'(out_ovf),   32'd0);
        send_beat(16'h0003, 16'h0002, 1'b1, 1'b0, lat);
        chk("post_rst_lat",  32'(lat),      32'd5);
        chk("post_rst_data", 32'(out_data), 32'h00007);
        chk("post_rst_ovf",  32'(out_ovf),  32'd0);
        finish_out(0, 1'b0);

        // Random groups against an exact-integer reference
        for (int g = 0; g < 1000; g++) begin
            nb    = $urandom_range(1, 8);
            hold  = 1'($urandom_range(0, 1));
            total = 0;
            for (int b = 0; b < nb; b++) begin
                s = pick();
                c = pick();
                l = (b == nb - 1);
                total += longint'(s) + 2 * longint'(c);
                send_beat(s, c, l, hold, lat);
            end
            chk("rand_data", 32'(out_data), 32'(total % (64'd1 << 20)));
            chk("rand_ovf",  32'(out_ovf),  32'(total > 64'hFFFFF));
            finish_out($urandom_range(0, 3), hold);
        end
        in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
